stack_bus_upstream_arbiter: RTL

//  Shares one stack-bus upstream lane between NUM_REQ PE requesters returning results to the manager array.

---
 rtl/stack_bus_arb_pkg.sv | 21 ++
 rtl/stack_bus_upstream_arbiter_rr_pick.sv | 33 +++
 rtl/stack_bus_upstream_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stack_bus_arb_pkg.sv
// Shared types and defaults for the stack-bus upstream arbiter.
// The beat struct below matches the default parameterisation.
package stack_bus_arb_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_DATA_W  = 64;
  localparam int ARB_SRC_W   = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [ARB_SRC_W-1:0]  src;
    logic [ARB_DATA_W-1:0] data;
  } up_beat_t;

endpackage

// File: rtl/stack_bus_upstream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo NUM_REQ, found by a double-width masked priority encoder.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] window;

  // The window covers positions ptr+1 .. ptr+NUM_REQ of the doubled vector;
  // scanning downward lets the lowest in-window position win.
  always_comb begin
    req_dbl = {req, req};
    window  = '0;
    gnt_idx = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      window[i] = (i > int'(ptr)) && (i <= int'(ptr) + NUM_REQ);
    end
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (req_dbl[i] && window[i]) begin
        gnt_idx = (i >= NUM_REQ) ? SRC_W'(i - NUM_REQ) : SRC_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/stack_bus_upstream_arbiter.sv
// Packet-locked round-robin arbiter sharing one stack-bus upstream lane
// between NUM_REQ PEs, with a single output register stage.
module stack_bus_upstream_arbiter
  import stack_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int SRC_W   = ARB_SRC_W
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_sop,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      up_valid,
  output logic                      up_sop,
  output logic                      up_eop,
  output logic [SRC_W-1:0]          up_src,
  output logic [DATA_W-1:0]         up_data,
  input  logic                      up_ready,
  output logic                      lane_busy,
  output logic                      err_proto
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } beat_t;

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             up_valid_q, up_valid_d;
  beat_t            beat_q, beat_d;

  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;
  logic              owner_ready;
  logic              owner_valid;
  logic              owner_sop;
  logic              owner_eop;
  logic [DATA_W-1:0] owner_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The owner may push whenever the output stage is empty or draining this cycle.
  assign owner_ready = ~up_valid_q | up_ready;
  assign owner_valid = req_valid[owner_q];
  assign owner_sop   = req_sop[owner_q];
  assign owner_eop   = req_eop[owner_q];
  assign owner_data  = req_data[int'(owner_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    first_d    = first_q;
    err_d      = err_q;
    up_valid_d = up_valid_q & ~up_ready;
    beat_d     = beat_q;
    req_ready  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          first_d = 1'b1;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        req_ready[owner_q] = owner_ready;
        if (owner_valid && owner_ready) begin
          up_valid_d = 1'b1;
          beat_d     = '{sop: owner_sop, eop: owner_eop, src: owner_q, data: owner_data};
          first_d    = 1'b0;
          // Malformed framing is flagged but the beat still goes out untouched.
          if ((first_q && !owner_sop) || (!first_q && owner_sop)) begin
            err_d = 1'b1;
          end
          if (owner_eop) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = owner_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= SRC_W'(NUM_REQ - 1);
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      up_valid_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      first_q    <= first_d;
      err_q      <= err_d;
      up_valid_q <= up_valid_d;
      beat_q     <= beat_d;
    end
  end

  assign up_valid  = up_valid_q;
  assign up_sop    = beat_q.sop;
  assign up_eop    = beat_q.eop;
  assign up_src    = beat_q.src;
  assign up_data   = beat_q.data;
  assign lane_busy = (state_q == ARB_LOCKED);
  assign err_proto = err_q;

endmodule
